// File: rtl/tetris_pkg.sv
// Shared types and constants for the locked-cell playfield store.
package tetris_pkg;

    localparam int ROWS_C = 20;
    localparam int COLS_C = 10;
    localparam int CW_C   = 3;

    typedef logic [2:0] color_t;
    typedef logic [4:0] row_idx_t;
    typedef logic [3:0] col_idx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        SCAN  = 3'd2,
        SHIFT = 3'd3,
        CHECK = 3'd4
    } board_state_t;

    localparam logic [19:0] SCORE_L1_C  = 20'd40;
    localparam logic [19:0] SCORE_L2_C  = 20'd100;
    localparam logic [19:0] SCORE_L3_C  = 20'd300;
    localparam logic [19:0] SCORE_L4_C  = 20'd1200;
    localparam logic [19:0] SCORE_MAX_C = 20'hFFFFF;

    function automatic logic [19:0] score_for_lines(input logic [2:0] lines);
        case (lines)
            3'd1:    return SCORE_L1_C;
            3'd2:    return SCORE_L2_C;
            3'd3:    return SCORE_L3_C;
            3'd4:    return SCORE_L4_C;
            default: return 20'd0;
        endcase
    endfunction

endpackage

// File: rtl/row_full_detect.sv
// Flags a playfield row in which every cell holds a non-empty colour.
module row_full_detect
    import tetris_pkg::*;
#(
    parameter int COLS = COLS_C,
    parameter int CW   = CW_C
) (
    input  logic [COLS-1:0][CW-1:0] row_i,
    output logic                    full_o
);

    // AND-reduce of per-cell occupancy
    always_comb begin
        full_o = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            full_o = full_o & (|row_i[c]);
        end
    end

endmodule

// File: rtl/static_board.sv
// Locked-cell playfield: writes landed pieces, clears full rows, compacts the stack.
// Optional scoring output enabled by defining STATIC_BOARD_SCORE_EN.
module static_board
    import tetris_pkg::*;
#(
    parameter int ROWS = ROWS_C,
    parameter int COLS = COLS_C,
    parameter int CW   = CW_C
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 En_New_Static,
    input  logic [3:0][4:0]      New_Static_Row,
    input  logic [3:0][3:0]      New_Static_Column,
    input  logic [CW-1:0]        New_Static_Color,
    input  logic [4:0]           Rd_Row,
    input  logic [3:0]           Rd_Col,
    output logic [CW-1:0]        Rd_Color,
    output logic                 Busy,
    output logic                 Lock_Done,
    output logic                 Overrun,
    output logic [2:0]           Lines_Last,
    output logic [15:0]          Lines_Total,
    output logic                 Game_Over
`ifdef STATIC_BOARD_SCORE_EN
    ,
    output logic [19:0]          Score
`endif
);

    localparam row_idx_t ROWS_L = row_idx_t'(ROWS);
    localparam col_idx_t COLS_L = col_idx_t'(COLS);

    board_state_t                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][CW-1:0] board_q, board_d;
    row_idx_t                         r_q, r_d;
    row_idx_t                         k_q, k_d;
    logic [2:0]                       lines_q, lines_d;
    logic [3:0][4:0]                  pc_row_q, pc_row_d;
    logic [3:0][3:0]                  pc_col_q, pc_col_d;
    logic [CW-1:0]                    pc_color_q, pc_color_d;
    logic                             en_hist_q;
    logic                             busy_q;
    logic                             go_q, go_d;
    logic                             done_q, done_d;
    logic                             overrun_q, overrun_d;
    logic [2:0]                       last_q, last_d;
    logic [15:0]                      total_q, total_d;
    logic                             rise_s;
    logic                             full_s;
`ifdef STATIC_BOARD_SCORE_EN
    logic [19:0]                      score_q, score_d;
    logic [20:0]                      score_sum_s;
`endif

    assign rise_s = En_New_Static & ~en_hist_q;

    row_full_detect #(.COLS(COLS), .CW(CW)) u_row_full (
        .row_i  (board_q[r_q]),
        .full_o (full_s)
    );

    // Next-state, board update and status computation
    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        r_d        = r_q;
        k_d        = k_q;
        lines_d    = lines_q;
        pc_row_d   = pc_row_q;
        pc_col_d   = pc_col_q;
        pc_color_d = pc_color_q;
        go_d       = go_q;
        done_d     = 1'b0;
        last_d     = last_q;
        total_d    = total_q;
`ifdef STATIC_BOARD_SCORE_EN
        score_d     = score_q;
        score_sum_s = {1'b0, score_q} + {1'b0, score_for_lines(lines_q)};
`endif
        overrun_d  = rise_s & ~go_q & (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (rise_s && !go_q) begin
                    pc_row_d   = New_Static_Row;
                    pc_col_d   = New_Static_Column;
                    pc_color_d = New_Static_Color;
                    state_d    = WRITE;
                end else begin
                    state_d    = IDLE;
                end
            end
            WRITE: begin
                // All cells are judged against the pre-write board, so duplicates never collide.
                for (int p = 0; p < 4; p++) begin
                    if ((pc_row_q[p] < ROWS_L) && (pc_col_q[p] < COLS_L) &&
                        (pc_color_q != {CW{1'b0}})) begin
                        if (board_q[pc_row_q[p]][pc_col_q[p]] != {CW{1'b0}}) begin
                            go_d = 1'b1;
                        end else begin
                            board_d[pc_row_q[p]][pc_col_q[p]] = pc_color_q;
                        end
                    end else begin
                        go_d = go_d;
                    end
                end
                r_d     = ROWS_L - 5'd1;
                lines_d = 3'd0;
                state_d = SCAN;
            end
            SCAN: begin
                if (full_s) begin
                    k_d     = r_q;
                    state_d = SHIFT;
                end else if (r_q == 5'd0) begin
                    state_d = CHECK;
                end else begin
                    r_d     = r_q - 5'd1;
                end
            end
            SHIFT: begin
                // The k==1 step also empties row 0, folding the final clear into the last move.
                for (int i = 1; i < ROWS; i++) begin
                    board_d[i] = (k_q == row_idx_t'(i)) ? board_q[i-1] : board_d[i];
                end
                if (k_q <= 5'd1) begin
                    board_d[0] = {(COLS*CW){1'b0}};
                    lines_d    = lines_q + 3'd1;
                    state_d    = SCAN;
                end else begin
                    k_d        = k_q - 5'd1;
                end
            end
            CHECK: begin
                go_d    = go_q | (|board_q[0]);
                last_d  = lines_q;
                total_d = total_q + {13'd0, lines_q};
                done_d  = 1'b1;
`ifdef STATIC_BOARD_SCORE_EN
                score_d = score_sum_s[20] ? SCORE_MAX_C : score_sum_s[19:0];
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            board_q    <= {(ROWS*COLS*CW){1'b0}};
            r_q        <= 5'd0;
            k_q        <= 5'd0;
            lines_q    <= 3'd0;
            pc_row_q   <= {20{1'b0}};
            pc_col_q   <= {16{1'b0}};
            pc_color_q <= {CW{1'b0}};
            en_hist_q  <= 1'b0;
            busy_q     <= 1'b0;
            go_q       <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            last_q     <= 3'd0;
            total_q    <= 16'd0;
`ifdef STATIC_BOARD_SCORE_EN
            score_q    <= 20'd0;
`endif
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            r_q        <= r_d;
            k_q        <= k_d;
            lines_q    <= lines_d;
            pc_row_q   <= pc_row_d;
            pc_col_q   <= pc_col_d;
            pc_color_q <= pc_color_d;
            en_hist_q  <= En_New_Static;
            busy_q     <= (state_d != IDLE);
            go_q       <= go_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            last_q     <= last_d;
            total_q    <= total_d;
`ifdef STATIC_BOARD_SCORE_EN
            score_q    <= score_d;
`endif
        end
    end

    // Renderer read port
    always_comb begin
        if ((Rd_Row < ROWS_L) && (Rd_Col < COLS_L)) begin
            Rd_Color = board_q[Rd_Row][Rd_Col];
        end else begin
            Rd_Color = {CW{1'b0}};
        end
    end

    assign Busy        = busy_q;
    assign Lock_Done   = done_q;
    assign Overrun     = overrun_q;
    assign Lines_Last  = last_q;
    assign Lines_Total = total_q;
    assign Game_Over   = go_q;
`ifdef STATIC_BOARD_SCORE_EN
    assign Score       = score_q;
`endif

endmodule

// File: tb/tb_static_board.sv
// Scoreboard bench for static_board: a reference playfield predicts each lock's outcome.
module tb_static_board;
    import tetris_pkg::*;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            En_New_Static;
    logic [3:0][4:0] New_Static_Row;
    logic [3:0][3:0] New_Static_Column;
    logic [2:0]      New_Static_Color;
    logic [4:0]      Rd_Row;
    logic [3:0]      Rd_Col;
    logic [2:0]      Rd_Color;
    logic            Busy, Lock_Done, Overrun, Game_Over;
    logic [2:0]      Lines_Last;
    logic [15:0]     Lines_Total;
`ifdef STATIC_BOARD_SCORE_EN
    logic [19:0]     Score;
`endif

    static_board dut (
        .Clk(Clk), .Reset(Reset), .En_New_Static(En_New_Static),
        .New_Static_Row(New_Static_Row), .New_Static_Column(New_Static_Column),
        .New_Static_Color(New_Static_Color), .Rd_Row(Rd_Row), .Rd_Col(Rd_Col),
        .Rd_Color(Rd_Color), .Busy(Busy), .Lock_Done(Lock_Done), .Overrun(Overrun),
        .Lines_Last(Lines_Last), .Lines_Total(Lines_Total), .Game_Over(Game_Over)
`ifdef STATIC_BOARD_SCORE_EN
        , .Score(Score)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int lines;
        int total;
        int go;
        int lat;
        int score;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] m_board [20][10];
    int         m_total;
    bit         m_go;
    int         m_score;

    function automatic logic [3:0][4:0] rows4(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [3:0][3:0] cols4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) m_board[r][c] = 3'd0;
        m_total = 0;
        m_go    = 1'b0;
        m_score = 0;
    endtask

    task automatic model_lock(input logic [3:0][4:0] rows, input logic [3:0][3:0] cols,
                              input logic [2:0] color);
        logic [2:0] snap [20][10];
        exp_t e;
        int   r, lines, lat, rr, cc;
        bit   full, scanning;
        snap = m_board;
        for (int p = 0; p < 4; p++) begin
            rr = int'(rows[p]);
            cc = int'(cols[p]);
            if (rr < 20 && cc < 10 && color != 3'd0) begin
                if (snap[rr][cc] != 3'd0) m_go = 1'b1;
                else m_board[rr][cc] = color;
            end
        end
        lines = 0; lat = 22; r = 19; scanning = 1'b1;
        while (scanning) begin
            full = 1'b1;
            for (int c = 0; c < 10; c++) if (m_board[r][c] == 3'd0) full = 1'b0;
            if (full) begin
                lines++;
                lat += (r == 0) ? 2 : r + 1;
                for (int i = r; i > 0; i--)
                    for (int c = 0; c < 10; c++) m_board[i][c] = m_board[i-1][c];
                for (int c = 0; c < 10; c++) m_board[0][c] = 3'd0;
            end else if (r == 0) begin
                scanning = 1'b0;
            end else begin
                r--;
            end
        end
        for (int c = 0; c < 10; c++) if (m_board[0][c] != 3'd0) m_go = 1'b1;
        m_total = (m_total + lines) % 65536;
        case (lines)
            1: m_score += 40;
            2: m_score += 100;
            3: m_score += 300;
            4: m_score += 1200;
            default: m_score += 0;
        endcase
        if (m_score > 32'hFFFFF) m_score = 32'hFFFFF;
        e = '{lines, m_total, int'(m_go), lat, m_score};
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int pre);
        int   busy_cnt;
        int   guard;
        exp_t e;
        busy_cnt = pre;
        guard    = 0;
        while (Lock_Done !== 1'b1 && guard < 1000) begin
            if (Busy === 1'b1) busy_cnt++;
            @(negedge Clk);
            guard++;
        end
        check_eq("lock_done_seen", Lock_Done, 1);
        check_eq("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("busy_cycles", busy_cnt, e.lat);
            check_eq("lines_last", Lines_Last, e.lines);
            check_eq("lines_total", Lines_Total, e.total);
            check_eq("game_over", Game_Over, e.go);
`ifdef STATIC_BOARD_SCORE_EN
            check_eq("score", Score, e.score);
`endif
        end
        @(negedge Clk);
        check_eq("lock_done_pulse", Lock_Done, 0);
    endtask

    task automatic do_lock(input logic [3:0][4:0] rows, input logic [3:0][3:0] cols,
                           input logic [2:0] color);
        bit taken;
        int bc, oc;
        taken             = !m_go;
        New_Static_Row    = rows;
        New_Static_Column = cols;
        New_Static_Color  = color;
        En_New_Static     = 1'b1;
        if (taken) model_lock(rows, cols, color);
        @(negedge Clk);
        En_New_Static = 1'b0;
        if (taken) begin
            wait_done(0);
        end else begin
            bc = 0; oc = 0;
            repeat (6) begin
                bc += int'(Busy);
                oc += int'(Overrun);
                @(negedge Clk);
            end
            check_eq("ignored_busy", bc, 0);
            check_eq("ignored_overrun", oc, 0);
        end
    endtask

    task automatic check_board(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 10; c++) begin
                Rd_Row = 5'(r);
                Rd_Col = 4'(c);
                #1;
                if (Rd_Color !== m_board[r][c]) bad++;
            end
        end
        check_eq(tag, bad, 0);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        En_New_Static = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int bc;
        Reset = 1'b1; En_New_Static = 1'b0;
        New_Static_Row = '0; New_Static_Column = '0; New_Static_Color = 3'd0;
        Rd_Row = 5'd0; Rd_Col = 4'd0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        model_reset();

        check_eq("rst_busy", Busy, 0);
        check_eq("rst_done", Lock_Done, 0);
        check_eq("rst_overrun", Overrun, 0);
        check_eq("rst_lines_last", Lines_Last, 0);
        check_eq("rst_lines_total", Lines_Total, 0);
        check_eq("rst_game_over", Game_Over, 0);
`ifdef STATIC_BOARD_SCORE_EN
        check_eq("rst_score", Score, 0);
`endif
        check_board("rst_board");

        // O piece on the floor
        do_lock(rows4(19, 19, 18, 18), cols4(4, 5, 4, 5), 3'd1);
        check_board("o_piece_board");
        Rd_Row = 5'd19; Rd_Col = 4'd4; #1;
        check_eq("o_piece_cell", Rd_Color, 1);
        Rd_Row = 5'd20; Rd_Col = 4'd4; #1;
        check_eq("rd_row_oor", Rd_Color, 0);
        Rd_Row = 5'd19; Rd_Col = 4'd10; #1;
        check_eq("rd_col_oor", Rd_Color, 0);
        @(negedge Clk);

        // Complete row 19, row 18 drops into it
        do_lock(rows4(19, 19, 19, 19), cols4(0, 1, 2, 3), 3'd2);
        do_lock(rows4(19, 19, 19, 19), cols4(6, 7, 8, 9), 3'd3);
        check_board("single_clear_board");
        check_eq("single_clear_total", Lines_Total, 1);

        // Skipped cells: out-of-range coordinates and colour 0
        do_lock(rows4(20, 17, 17, 17), cols4(3, 10, 0, 1), 3'd7);
        do_lock(rows4(15, 15, 15, 15), cols4(0, 1, 2, 3), 3'd0);
        check_board("skip_board");

        // Four-line clear
        do_reset();
        for (int r = 16; r < 20; r++) begin
            do_lock(rows4(r, r, r, r), cols4(0, 1, 2, 3), 3'd4);
            do_lock(rows4(r, r, r, r), cols4(4, 5, 6, 7), 3'd5);
            do_lock(rows4(r, r, r, r), cols4(8, 8, 8, 8), 3'd6);
        end
        do_lock(rows4(16, 17, 18, 19), cols4(9, 9, 9, 9), 3'd3);
        check_eq("tetris_lines", Lines_Last, 4);
`ifdef STATIC_BOARD_SCORE_EN
        check_eq("tetris_score", Score, 1200);
`endif
        check_board("tetris_board");

        // Reset in the middle of a row shift
        do_lock(rows4(19, 19, 19, 19), cols4(0, 1, 2, 3), 3'd2);
        do_lock(rows4(19, 19, 19, 19), cols4(4, 5, 6, 7), 3'd2);
        New_Static_Row    = rows4(19, 19, 18, 18);
        New_Static_Column = cols4(8, 9, 8, 9);
        New_Static_Color  = 3'd5;
        En_New_Static     = 1'b1;
        @(negedge Clk);
        En_New_Static = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("busy_in_shift", Busy, 1);
        Reset = 1'b1; En_New_Static = 1'b1;
        @(negedge Clk);
        model_reset();
        check_eq("midrst_busy", Busy, 0);
        check_eq("midrst_total", Lines_Total, 0);
        check_eq("midrst_done", Lock_Done, 0);
        check_board("midrst_board");
        bc = 0;
        repeat (3) begin
            bc += int'(Busy);
            @(negedge Clk);
        end
        check_eq("midrst_no_lock", bc, 0);
        En_New_Static = 1'b0;
        Reset = 1'b0;
        @(negedge Clk);

        // Second edge while busy is dropped
        do_reset();
        New_Static_Row = rows4(19, 19, 19, 19); New_Static_Column = cols4(0, 1, 2, 3);
        New_Static_Color = 3'd6; En_New_Static = 1'b1;
        model_lock(rows4(19, 19, 19, 19), cols4(0, 1, 2, 3), 3'd6);
        @(negedge Clk); En_New_Static = 1'b0; bc = int'(Busy);
        @(negedge Clk); bc += int'(Busy);
        @(negedge Clk); bc += int'(Busy);
        New_Static_Row = rows4(10, 10, 10, 10); New_Static_Column = cols4(5, 6, 7, 8);
        New_Static_Color = 3'd2; En_New_Static = 1'b1;
        @(negedge Clk); bc += int'(Busy);
        check_eq("overrun_pulse", Overrun, 1);
        En_New_Static = 1'b0;
        @(negedge Clk);
        check_eq("overrun_one_cycle", Overrun, 0);
        wait_done(bc);
        check_board("overrun_board");

        // Game over by collision, then lock requests ignored
        do_reset();
        do_lock(rows4(19, 19, 19, 19), cols4(0, 1, 2, 3), 3'd2);
        do_lock(rows4(19, 19, 18, 18), cols4(3, 4, 3, 4), 3'd5);
        check_eq("go_collision", Game_Over, 1);
        do_lock(rows4(10, 10, 10, 10), cols4(0, 1, 2, 3), 3'd6);
        check_board("go_collision_board");

        // Game over by a cell left in row 0
        do_reset();
        do_lock(rows4(0, 1, 2, 3), cols4(0, 0, 0, 0), 3'd1);
        check_eq("go_row0", Game_Over, 1);
        do_lock(rows4(19, 19, 19, 19), cols4(0, 1, 2, 3), 3'd3);
        check_board("go_row0_board");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
